loop_sequencer: RTL

LOOP_SEQUENCER -- requirements
Module: loop_sequencer

---
 rtl/loop_seq_pkg.sv | 25 ++
 rtl/loop_seq_alu.sv | 36 +++
 rtl/loop_sequencer.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/loop_seq_pkg.sv
// Shared types and default widths for the loop sequencer.
package loop_seq_pkg;

  localparam int DEF_IDX_W = 8;
  localparam int DEF_ACC_W = 16;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_MUL  = 4'd2,
    OP_AND  = 4'd3,
    OP_OR   = 4'd4,
    OP_XOR  = 4'd5,
    OP_SHL  = 4'd6,
    OP_SHR  = 4'd7,
    OP_ASHR = 4'd8
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/loop_seq_alu.sv
// Combinational accumulator update: res = acc OP operand, truncated to ACC_W.
module loop_seq_alu
  import loop_seq_pkg::*;
#(
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic [ACC_W-1:0] acc_i,
  input  logic [ACC_W-1:0] opnd_i,
  input  logic [3:0]       op_i,
  output logic [ACC_W-1:0] res_o
);

  localparam logic [ACC_W:0] SH_LIM = (ACC_W+1)'(ACC_W);

  logic big_shift;
  assign big_shift = ({1'b0, opnd_i} >= SH_LIM);

  // Opcode decode; unknown codes pass the accumulator through.
  always_comb begin
    res_o = acc_i;
    case (op_i)
      OP_ADD:  res_o = acc_i + opnd_i;
      OP_SUB:  res_o = acc_i - opnd_i;
      OP_MUL:  res_o = acc_i * opnd_i;
      OP_AND:  res_o = acc_i & opnd_i;
      OP_OR:   res_o = acc_i | opnd_i;
      OP_XOR:  res_o = acc_i ^ opnd_i;
      OP_SHL:  res_o = big_shift ? '0 : (acc_i << opnd_i);
      OP_SHR:  res_o = big_shift ? '0 : (acc_i >> opnd_i);
      OP_ASHR: res_o = big_shift ? {ACC_W{acc_i[ACC_W-1]}}
                                 : ACC_W'($signed(acc_i) >>> opnd_i);
      default: res_o = acc_i;
    endcase
  end

endmodule

// File: rtl/loop_sequencer.sv
// Programmable for-loop engine: emits an index stream with a ready/valid
// handshake and folds each accepted index into an accumulator.
//
//   state   | meaning
//   IDLE    | waiting for start; results of the last loop held
//   RUN     | presenting indices while the continue condition holds
//   DONE    | one-cycle completion pulse, then back to IDLE
module loop_sequencer
  import loop_seq_pkg::*;
#(
  parameter int IDX_W = DEF_IDX_W,
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [IDX_W-1:0] cfg_begin,
  input  logic [IDX_W-1:0] cfg_end,
  input  logic [IDX_W-1:0] cfg_step,
  input  logic             cfg_step_mul,
  input  logic             cfg_down,
  input  logic             cfg_incl,
  input  logic             cfg_brk_en,
  input  logic [IDX_W-1:0] cfg_brk_val,
  input  logic [3:0]       cfg_op,
  output logic             idx_valid,
  input  logic             idx_ready,
  output logic [IDX_W-1:0] idx,
  output logic [ACC_W-1:0] acc,
  output logic             busy,
  output logic             done,
  output logic             broke
);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             broke_q, broke_d;

  logic [IDX_W-1:0] end_q, step_q, brk_val_q;
  logic             mul_q, down_q, incl_q, brk_en_q;
  logic [3:0]       op_q;

  logic             accept;
  logic             down_eff;
  logic [IDX_W:0]   addsub_w;
  logic [2*IDX_W-1:0] prod_w;
  logic [IDX_W-1:0] next_idx;
  logic             wrap;
  logic             cont_now;
  logic             cont_next;
  logic             brk_hit;
  logic [ACC_W-1:0] alu_res;

  function automatic logic cont_f(input logic [IDX_W-1:0] i,
                                  input logic [IDX_W-1:0] e,
                                  input logic dn,
                                  input logic inc);
    if (dn) return inc ? (i >= e) : (i > e);
    else    return inc ? (i <= e) : (i < e);
  endfunction

  assign accept   = (state_q == ST_IDLE) && start;
  // Multiply mode always walks upward regardless of the direction bit.
  assign down_eff = down_q && !mul_q;
  assign addsub_w = down_eff ? ({1'b0, idx_q} - {1'b0, step_q})
                             : ({1'b0, idx_q} + {1'b0, step_q});
  assign prod_w   = {{IDX_W{1'b0}}, idx_q} * {{IDX_W{1'b0}}, step_q};
  assign next_idx = mul_q ? prod_w[IDX_W-1:0] : addsub_w[IDX_W-1:0];
  assign wrap     = mul_q ? |prod_w[2*IDX_W-1:IDX_W] : addsub_w[IDX_W];
  assign cont_now  = cont_f(idx_q, end_q, down_eff, incl_q);
  assign cont_next = cont_f(next_idx, end_q, down_eff, incl_q);
  assign brk_hit   = brk_en_q && (idx_q == brk_val_q);

  loop_seq_alu #(.ACC_W(ACC_W)) u_alu (
    .acc_i  (acc_q),
    .opnd_i (ACC_W'(idx_q)),
    .op_i   (op_q),
    .res_o  (alu_res)
  );

  // Loop configuration is captured only when a start is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      end_q     <= '0;
      step_q    <= '0;
      brk_val_q <= '0;
      mul_q     <= 1'b0;
      down_q    <= 1'b0;
      incl_q    <= 1'b0;
      brk_en_q  <= 1'b0;
      op_q      <= '0;
    end else if (accept) begin
      end_q     <= cfg_end;
      step_q    <= cfg_step;
      brk_val_q <= cfg_brk_val;
      mul_q     <= cfg_step_mul;
      down_q    <= cfg_down;
      incl_q    <= cfg_incl;
      brk_en_q  <= cfg_brk_en;
      op_q      <= cfg_op;
    end
  end

  // State, index, accumulator and break flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      acc_q   <= '0;
      broke_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      broke_q <= broke_d;
    end
  end

  // Next-state logic: iterate on handshake, stop on bound, wrap, stall or break.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    broke_d = broke_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          idx_d   = cfg_begin;
          acc_d   = '0;
          broke_d = 1'b0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!cont_now) begin
          state_d = ST_DONE;
        end else if (idx_ready) begin
          acc_d = alu_res;
          idx_d = next_idx;
          if (brk_hit) begin
            broke_d = 1'b1;
            state_d = ST_DONE;
          end else if (!cont_next || wrap || (next_idx == idx_q)) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign idx_valid = (state_q == ST_RUN) && cont_now;
  assign idx       = idx_q;
  assign acc       = acc_q;
  assign broke     = broke_q;
  assign done      = (state_q == ST_DONE);
  assign busy      = (state_q == ST_RUN) || (state_q == ST_DONE);

endmodule
